// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 types, S-box tables, GF(2^8) helpers and key-schedule steps
package aes_pkg;
  typedef logic [127:0] state_t;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {S_IDLE, S_KEXP, S_ROUND, S_FINAL} fsm_e;
  localparam int NR = 10;
  localparam int KEXP_CYCLES = 10;
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [0:15][7:0] RCON = {
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };
  function automatic logic [0:255][7:0] gen_inv_sbox();
    logic [0:255][7:0] t;
    t = '0;
    for (int i = 0; i < 256; i++) t[SBOX[i]] = 8'(i);
    return t;
  endfunction
  localparam logic [0:255][7:0] INV_SBOX = gen_inv_sbox();
  function automatic logic [7:0] sbox(logic [7:0] b);
    return SBOX[b];
  endfunction
  function automatic logic [7:0] inv_sbox(logic [7:0] b);
    return INV_SBOX[b];
  endfunction
  function automatic logic [7:0] rcon(logic [3:0] i);
    return RCON[i];
  endfunction
  function automatic logic [7:0] gf_xtime(logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = gf_xtime(x);
    end
    return p;
  endfunction
  // Byte i of a block sits at bits [127-8i -: 8]; byte i is row i%4, column i/4.
  function automatic logic [7:0] get_byte(state_t s, int i);
    return s[127 - 8 * i -: 8];
  endfunction
  function automatic word_t sub_rot(word_t w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction
  function automatic state_t key_fwd(state_t k, logic [7:0] rc);
    word_t w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction
  function automatic state_t key_inv(state_t k, logic [7:0] rc);
    word_t w0, w1, w2, w3;
    w3 = k[31:0] ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_rot(w3) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction
endpackage

// File: rtl/aes_inv_round.sv
// aes_inv_round: one combinational AES inverse round; InvMixColumns skipped when i_last=1
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] i_state,
  input  logic [127:0] i_rk,
  input  logic         i_last,
  output logic [127:0] o_state
);
  logic [127:0] w_ark, w_mix;
  always_comb begin
    w_ark = '0;
    w_mix = '0;
    for (int i = 0; i < 16; i++)
      w_ark[127 - 8 * i -: 8] = inv_sbox(get_byte(i_state, 4 * ((i / 4 - i % 4 + 4) % 4) + i % 4)) ^ get_byte(i_rk, i);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        w_mix[127 - 8 * (4 * c + r) -: 8] = gf_mul(get_byte(w_ark, 4 * c + r), 8'h0e)
          ^ gf_mul(get_byte(w_ark, 4 * c + (r + 1) % 4), 8'h0b)
          ^ gf_mul(get_byte(w_ark, 4 * c + (r + 2) % 4), 8'h0d)
          ^ gf_mul(get_byte(w_ark, 4 * c + (r + 3) % 4), 8'h09);
  end
  assign o_state = i_last ? w_ark : w_mix;
endmodule

// File: rtl/aes_decryptor.sv
// aes_decryptor: iterative AES-128 inverse cipher, forward key expansion then one inverse round per clock
module aes_decryptor
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key,
  output logic         ready,
  output logic         done,
  output logic [127:0] plaintext
);
  fsm_e         r_fsm, w_fsm_next;
  logic [3:0]   r_ctr;
  logic [127:0] r_state, r_rk, r_pt;
  logic         r_done;
  logic [127:0] w_rk_fwd, w_rk_inv, w_round;
  logic         w_last;
  assign w_rk_fwd = key_fwd(r_rk, rcon(r_ctr));
  // r_rk holds round key ctr+1 while walking back; in FINAL ctr=0 so this yields rk0.
  assign w_rk_inv = key_inv(r_rk, rcon(r_ctr + 4'd1));
  assign w_last = r_fsm == S_FINAL;
  aes_inv_round u_round (
    .i_state(r_state),
    .i_rk   (w_rk_inv),
    .i_last (w_last),
    .o_state(w_round)
  );
  always_ff @(posedge clk)
    r_fsm <= rst ? S_IDLE : w_fsm_next;
  always_comb begin
    w_fsm_next = r_fsm;
    case (r_fsm)
      S_IDLE:  w_fsm_next = start ? S_KEXP : S_IDLE;
      S_KEXP:  w_fsm_next = r_ctr == 4'(KEXP_CYCLES) ? S_ROUND : S_KEXP;
      S_ROUND: w_fsm_next = r_ctr == 4'd1 ? S_FINAL : S_ROUND;
      default: w_fsm_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctr   <= '0;
      r_state <= '0;
      r_rk    <= '0;
      r_pt    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= r_fsm == S_FINAL;
      case (r_fsm)
        S_IDLE: if (start) begin
          r_state <= ciphertext;
          r_rk    <= key;
          r_ctr   <= 4'd1;
        end
        S_KEXP: begin
          r_rk  <= w_rk_fwd;
          r_ctr <= r_ctr == 4'(KEXP_CYCLES) ? 4'(NR - 1) : r_ctr + 4'd1;
          if (r_ctr == 4'(KEXP_CYCLES)) r_state <= r_state ^ w_rk_fwd;
        end
        S_ROUND: begin
          r_state <= w_round;
          r_rk    <= w_rk_inv;
          r_ctr   <= r_ctr - 4'd1;
        end
        default: r_pt <= w_round;
      endcase
    end
  end
  assign ready = r_fsm == S_IDLE;
  assign done = r_done;
  assign plaintext = r_pt;
endmodule
